// File: rtl/ram_pkg.sv
// ============================================================================
//  Module : ram_pkg
//  Brief  : Shared types, constants and helpers for the dual-port RAM slice.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } ram_state_t;

    // On a same-address double write, port 1's data is the one kept.
    localparam bit RAM_WRITE_PRIORITY_PORT1 = 1'b1;

    function automatic int ram_aw(input int kb);
        return $clog2(kb * 1024);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dp_if.sv
// ============================================================================
//  Module : ram_dp_if
//  Brief  : Two-port access bundle (address, data, write enable, read data).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_dp_if #(
    parameter int AW = 10,
    parameter int DW = 8
);

    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          w1;
    logic [DW-1:0] q1;

    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
    logic          w2;
    logic [DW-1:0] q2;

    modport master (
        output a1, d1, w1, a2, d2, w2,
        input  q1, q2
    );

    modport slave (
        input  a1, d1, w1, a2, d2, w2,
        output q1, q2
    );

endinterface

`default_nettype wire

// File: rtl/ram_dp_fill.sv
// ============================================================================
//  Module : ram_dp_fill
//  Brief  : Post-reset fill sequencer; walks every address once, then RUN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_dp_fill
    import ram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  wire logic          clock,
    input  wire logic          reset,
    output logic [AW-1:0]      fill_addr_o,
    output logic               fill_we_o,
    output logic               ready_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ram_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic          ready_q, ready_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                // Leave FILL on the edge that writes the last word.
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    assign fill_addr_o = cnt_q;
    assign fill_we_o   = (state_q == FILL);
    assign ready_o     = ready_q;

endmodule

`default_nettype wire

// File: rtl/ram_dp.sv
// ============================================================================
//  Module : ram_dp
//  Brief  : True dual-port synchronous RAM with post-reset fill engine.
//           Optional macro RAM_DP_OUTREG_EN adds an output register stage.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_dp #(
    parameter int            KB   = 1,
    parameter int            DW   = 8,
    parameter logic [DW-1:0] FILL = '0
) (
    input  wire logic  clock,
    input  wire logic  reset,
    output logic       ready,
    ram_dp_if.slave    bus
);

    import ram_pkg::ram_aw;
    import ram_pkg::RAM_WRITE_PRIORITY_PORT1;

    localparam int DEPTH = KB * 1024;
    localparam int AW    = ram_aw(KB);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] w_fill_addr;
    logic          w_fill_we;
    logic          w_fill_ready;
    logic          w_same_addr;
    logic          w_wr1;
    logic          w_wr2;

    logic [DW-1:0] q1_q;
    logic [DW-1:0] q2_q;

    ram_dp_fill #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fill (
        .clock       (clock),
        .reset       (reset),
        .fill_addr_o (w_fill_addr),
        .fill_we_o   (w_fill_we),
        .ready_o     (w_fill_ready)
    );

    // Same-address double write: only the priority port commits.
    assign w_same_addr = (bus.a1 == bus.a2);
    assign w_wr1 = bus.w1 && !(!RAM_WRITE_PRIORITY_PORT1 && bus.w2 && w_same_addr);
    assign w_wr2 = bus.w2 && !( RAM_WRITE_PRIORITY_PORT1 && bus.w1 && w_same_addr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_fill_we) begin
                mem[w_fill_addr] <= FILL;
            end else begin
                if (w_wr1) begin
                    mem[bus.a1] <= bus.d1;
                end
                if (w_wr2) begin
                    mem[bus.a2] <= bus.d2;
                end
            end
        end
    end

    // Reads sample the array before this edge's writes land (old data cross-port).
    always_ff @(posedge clock) begin
        if (reset) begin
            q1_q <= '0;
            q2_q <= '0;
        end else if (w_fill_we) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= bus.w1 ? bus.d1 : mem[bus.a1];
            q2_q <= bus.w2 ? bus.d2 : mem[bus.a2];
        end
    end

`ifdef RAM_DP_OUTREG_EN
    logic [DW-1:0] q1_out_q;
    logic [DW-1:0] q2_out_q;
    logic          ready_out_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q1_out_q    <= '0;
            q2_out_q    <= '0;
            ready_out_q <= 1'b0;
        end else begin
            q1_out_q    <= q1_q;
            q2_out_q    <= q2_q;
            ready_out_q <= w_fill_ready;
        end
    end

    assign bus.q1 = q1_out_q;
    assign bus.q2 = q2_out_q;
    assign ready  = ready_out_q;
`else
    assign bus.q1 = q1_q;
    assign bus.q2 = q2_q;
    assign ready  = w_fill_ready;
`endif

endmodule

`default_nettype wire
